drop_timer_ctrl: RTL
====================

Name: drop_timer_ctrl

Overview:
- Sequences an external cascade of STAGES 74LS161-style 4-bit synchronous counters. The cascade acts as the programmable gravity timer for falling pieces.
- Computes a preset from the current level or soft-drop mode, loads it, enables counting, and detects terminal count. On terminal count it emits a one-cycle drop_tick to the piece-movement logic and reloads.
- Handles start, stop, pause and soft-drop restart.

Parameters:
- STAGES, 3, number of cascaded 4-bit counter stages; W = 4*STAGES.
- BASE_PERIOD, 3000, tick period in cycles at level 0.
- LEVEL_STEP, 250, period reduction per level.
- MIN_PERIOD, 250, lower clamp on the level period; must be >= 2.
- SOFT_PERIOD, 100, tick period while soft_drop=1; must be >= 2.
- All periods must be <= 2^W.

Ports:
- CP  in  1  system clock, rising edge.
- CRn  in  1  reset, synchronous, active-low.
- start  in  1  level-sensitive; arms the timer from IDLE.
- stop  in  1  returns to IDLE; priority over all inputs except CRn.
- pause  in  1  freezes the timer while high.
- soft_drop  in  1  selects SOFT_PERIOD.
- level  in  4  game level 0..15.
- cnt_tc  in  1  cascade terminal count: all stages Q = 4'hF (AND of every stage CO).
- cnt_LDn  out  1  parallel-load enable to all stages, active-low.
- cnt_D  out  W  preset bus; stage k takes cnt_D[4k+3:4k].
- cnt_en  out  1  drives CTT and CTP of stage 0; higher stages chain on CO.
- drop_tick  out  1  one-cycle gravity pulse.
- busy  out  1  high whenever state != IDLE.
- paused  out  1  high in PAUSE.

Behaviour:
- Reset: synchronous; CRn=0 at a CP edge gives state=IDLE, preset register=0, soft_q=0.
  - Outputs after reset: cnt_LDn=1, cnt_en=0, cnt_D=0, drop_tick=0, busy=0, paused=0.
  - Counter stages share the system CRn, so they clear too.
- Period: T = soft_drop ? SOFT_PERIOD : max(BASE_PERIOD - level*LEVEL_STEP, MIN_PERIOD).
  - Evaluate in W+6-bit signed arithmetic so the subtraction cannot wrap before the clamp.
  - Preset P = 2^W + 1 - T, truncated to W bits.
  - P is registered on entry to LOAD or TICK; cnt_D = preset register.
- Outputs are Moore, decoded from state:
  - IDLE: LDn=1, en=0.
  - LOAD: LDn=0, en=0.
  - RUN: LDn=1, en=1.
  - TICK: LDn=0, en=0, drop_tick=1.
  - PAUSE: LDn=1, en=0, paused=1.
- Transitions (stop=1 in any state sends it to IDLE next cycle, with no drop_tick):
  - IDLE -> LOAD when start=1.
  - LOAD -> RUN, or -> PAUSE if pause=1.
  - RUN -> TICK when cnt_tc=1.
  - RUN -> LOAD on a soft_drop rising edge (soft_drop=1, soft_q=0). This restarts immediately with SOFT_PERIOD. cnt_tc has priority over the restart in the same cycle.
  - RUN -> PAUSE when pause=1 and cnt_tc=0.
  - TICK -> RUN, or -> PAUSE if pause=1. The tick is still emitted.
  - PAUSE -> RUN when pause=0. No reload; the count resumes from the held value.
- Timing: the LOAD cycle is followed by 2^W-P RUN cycles and then TICK. Consecutive drop_ticks are exactly T cycles apart in steady state.
- Pause of N cycles delays the next tick by exactly N cycles.
- soft_drop falling edge and level changes do not restart the timer. They take effect at the next TICK reload.
- soft_q registers soft_drop every cycle; it is cleared by reset.
- cnt_tc is ignored outside RUN.

Test Plan:
- Bench instantiates a 2-stage 161-style counter cascade. Overrides: STAGES=2, BASE_PERIOD=20, LEVEL_STEP=4, MIN_PERIOD=6, SOFT_PERIOD=3.
- Level 0, start pulse -> cnt_D=237 with cnt_LDn=0 in the LOAD cycle; first drop_tick 20 cycles after LOAD, then every 20 cycles; busy=1.
- Level 3 -> T=8, cnt_D=249. Level 5 and level 15 -> clamp to T=6, cnt_D=251. Ticks every 6 cycles.
- Level 0, assert soft_drop 7 cycles after LOAD -> LOAD the next cycle with cnt_D=254, ticks every 3 cycles. Deassert -> T=20 from the next reload; no extra tick.
- Pause held 10 cycles mid-RUN -> cnt_en=0 and counter Q held; paused=1; next tick arrives 30 cycles after the previous one. Pause asserted on the TICK cycle -> tick still pulses, then PAUSE.
- stop mid-RUN -> IDLE next cycle, no drop_tick, busy=0, cnt_en=0. CRn=0 mid-RUN -> all outputs at reset values after that edge; a new start resumes normal ticking.

Source files
------------

// File: rtl/drop_timer_ctrl.sv
// Gravity-timer sequencer for an external cascade of 161-style 4-bit counters.
// Computes the reload preset from level / soft-drop, drives load and enable,
// and turns the cascade's terminal count into a one-cycle drop_tick.
module drop_timer_ctrl #(
  parameter int STAGES      = 3,
  parameter int BASE_PERIOD = 3000,
  parameter int LEVEL_STEP  = 250,
  parameter int MIN_PERIOD  = 250,
  parameter int SOFT_PERIOD = 100
) (
  input  logic                  CP,
  input  logic                  CRn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  soft_drop,
  input  logic [3:0]            level,
  input  logic                  cnt_tc,
  output logic                  cnt_LDn,
  output logic [4*STAGES-1:0]   cnt_D,
  output logic                  cnt_en,
  output logic                  drop_tick,
  output logic                  busy,
  output logic                  paused
);

  localparam int W  = 4 * STAGES;
  // Six spare bits keep BASE - 15*STEP from wrapping before the clamp.
  localparam int PW = W + 6;

  localparam logic signed [PW-1:0] BASE_S = PW'(BASE_PERIOD);
  localparam logic signed [PW-1:0] STEP_S = PW'(LEVEL_STEP);
  localparam logic signed [PW-1:0] MIN_S  = PW'(MIN_PERIOD);
  localparam logic signed [PW-1:0] SOFT_S = PW'(SOFT_PERIOD);
  // The cascade counts P .. 2^W-1 and wraps, so P = 2^W + 1 - T gives T cycles
  // between ticks once the load/tick cycle is included.
  localparam logic signed [PW-1:0] FULL_S = PW'((1 << W) + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    TICK,
    PAUSE
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic                   soft_q;
  logic                   soft_rise;
  logic [W-1:0]           preset_q;
  logic [W-1:0]           preset_calc;
  logic signed [PW-1:0]   level_s;
  logic signed [PW-1:0]   level_period;
  logic signed [PW-1:0]   period;

  assign soft_rise = soft_drop & ~soft_q;
  assign cnt_D     = preset_q;

  // Period selection and preset arithmetic for the next reload.
  // NOTE: combinational blocks use blocking '=' so later lines see the updated
  // value (level_period is refined in place); every target gets a value first.
  always_comb begin
    level_s      = $signed({{(PW-4){1'b0}}, level});
    level_period = BASE_S - level_s * STEP_S;
    if (level_period < MIN_S) level_period = MIN_S;
    period       = soft_drop ? SOFT_S : level_period;
    preset_calc  = W'(FULL_S - period);
  end

  // State register.
  // NOTE: clocked state uses non-blocking '<=' so every register samples
  // pre-edge values and the simulation order of blocks cannot matter.
  always_ff @(posedge CP) begin
    if (!CRn) state <= IDLE;
    else      state <= next_state;
  end

  // Preset capture on entry to LOAD/TICK; soft_drop history for edge detect.
  always_ff @(posedge CP) begin
    if (!CRn) begin
      preset_q <= '0;
      soft_q   <= 1'b0;
    end else begin
      soft_q <= soft_drop;
      if ((next_state == LOAD) || (next_state == TICK)) preset_q <= preset_calc;
    end
  end

  // Next-state decode; stop overrides everything, cnt_tc beats a soft restart.
  always_comb begin
    next_state = state;
    if (stop) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) next_state = LOAD;
        LOAD:    next_state = pause ? PAUSE : RUN;
        RUN: begin
          if (cnt_tc)         next_state = TICK;
          else if (soft_rise) next_state = LOAD;
          else if (pause)     next_state = PAUSE;
        end
        TICK:    next_state = pause ? PAUSE : RUN;
        PAUSE:   if (!pause) next_state = RUN;
        default: next_state = IDLE;
      endcase
    end
  end

  // Moore outputs decoded from state; TICK doubles as the reload cycle.
  always_comb begin
    cnt_LDn   = 1'b1;
    cnt_en    = 1'b0;
    drop_tick = 1'b0;
    paused    = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE:  ;
      LOAD:  cnt_LDn = 1'b0;
      RUN:   cnt_en  = 1'b1;
      TICK: begin
        cnt_LDn   = 1'b0;
        drop_tick = 1'b1;
      end
      PAUSE: paused = 1'b1;
      default: ;
    endcase
  end

endmodule
